// File: rtl/bist_pkg.sv
// Shared types and defaults for the BIST test pattern generator.
// Optional feature macro: TPG_ALLZERO_EN (inserts the all-zero pattern, period 64).
package bist_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int unsigned TPG_WIDTH = 6;
  localparam int unsigned IDX_W     = 7;
  localparam logic [TPG_WIDTH-1:0] TPG_SEED = 6'h01;
  localparam logic [TPG_WIDTH-1:0] TPG_TAPS = 6'b110000;

`ifdef TPG_ALLZERO_EN
  localparam int unsigned TPG_N_PATTERNS = 64;
`else
  localparam int unsigned TPG_N_PATTERNS = 63;
`endif

endpackage

// File: rtl/bist_tpg_ctrl_if.sv
// Pattern/strobe bundle between the TPG controller and its consumers.
interface bist_tpg_ctrl_if #(
  parameter int unsigned WIDTH = 6
);
  logic             start;
  logic [WIDTH-1:0] pattern;
  logic             pattern_valid;
  logic [6:0]       pat_idx;
  logic             last;
  logic             misr_clr;
  logic             sig_capture;
  logic             busy;
  logic             done;

  // TPG side: drives patterns and session strobes
  modport master (
    input  start,
    output pattern, pattern_valid, pat_idx, last,
    output misr_clr, sig_capture, busy, done
  );

  // Consumer side: requests sessions, observes patterns
  modport slave (
    output start,
    input  pattern, pattern_valid, pat_idx, last,
    input  misr_clr, sig_capture, busy, done
  );
endinterface

// File: rtl/lfsr_core.sv
// Fibonacci-style shift-left LFSR with optional de Bruijn zero insertion.
// Optional feature macro: TPG_ALLZERO_EN.
module lfsr_core #(
  parameter int unsigned           WIDTH = 6,
  parameter logic [WIDTH-1:0]      TAPS  = 6'b110000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic             adv,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_q;
  logic             w_fb;

  // Feedback bit; zero insertion splices 00 between 10..0 and 00..1
  always_comb begin
    w_fb = ^(r_q & TAPS);
`ifdef TPG_ALLZERO_EN
    w_fb = w_fb ^ (r_q[WIDTH-2:0] == '0);
`endif
  end

  // State register: reset and load both return to the seed
  always_ff @(posedge clk) begin
    if (reset || load) begin
      r_q <= seed;
    end else if (adv) begin
      r_q <= {r_q[WIDTH-2:0], w_fb};
    end
  end

  assign q = r_q;

endmodule

// File: rtl/bist_tpg_ctrl.sv
// BIST session sequencer: clears the compactor, applies N_PATTERNS LFSR
// patterns, then flags the signature capture point.
// Optional feature macro: TPG_ALLZERO_EN (64 patterns including 00).
module bist_tpg_ctrl
  import bist_pkg::*;
#(
  parameter int unsigned      WIDTH      = TPG_WIDTH,
  parameter logic [WIDTH-1:0] SEED       = WIDTH'(TPG_SEED),
  parameter logic [WIDTH-1:0] TAPS       = WIDTH'(TPG_TAPS),
  parameter int unsigned      N_PATTERNS = TPG_N_PATTERNS
) (
  input  logic            clk,
  input  logic            reset,
  bist_tpg_ctrl_if.master tpg
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_PATTERNS - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDX_W-1:0] r_pat_idx;
  logic [IDX_W-1:0] w_pat_idx_nxt;
  logic             w_load;
  logic             w_adv;
  logic [WIDTH-1:0] w_lfsr_q;

  logic r_valid;
  logic r_last;
  logic r_misr_clr;
  logic r_sig_capture;
  logic r_busy;
  logic r_done;

  lfsr_core #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS)
  ) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .load  (w_load),
    .seed  (SEED),
    .adv   (w_adv),
    .q     (w_lfsr_q)
  );

  // Next-state, counter and LFSR control
  always_comb begin
    w_state_nxt   = r_state;
    w_pat_idx_nxt = r_pat_idx;
    w_load        = 1'b0;
    w_adv         = 1'b0;
    case (r_state)
      IDLE: begin
        if (tpg.start) w_state_nxt = LOAD;
      end
      LOAD: begin
        w_load        = 1'b1;
        w_pat_idx_nxt = '0;
        w_state_nxt   = RUN;
      end
      RUN: begin
        if (r_pat_idx == LAST_IDX) begin
          w_state_nxt = DONE;
        end else begin
          w_adv         = 1'b1;
          w_pat_idx_nxt = r_pat_idx + IDX_W'(1);
        end
      end
      DONE: begin
        if (tpg.start) w_state_nxt = LOAD;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State, counter and registered strobes decoded from the next state
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_pat_idx     <= '0;
      r_valid       <= 1'b0;
      r_last        <= 1'b0;
      r_misr_clr    <= 1'b0;
      r_sig_capture <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_pat_idx     <= w_pat_idx_nxt;
      r_valid       <= (w_state_nxt == RUN);
      r_last        <= (w_state_nxt == RUN) && (w_pat_idx_nxt == LAST_IDX);
      r_misr_clr    <= (w_state_nxt == LOAD);
      r_sig_capture <= (w_state_nxt == DONE) && (r_state != DONE);
      r_busy        <= (w_state_nxt == LOAD) || (w_state_nxt == RUN);
      r_done        <= (w_state_nxt == DONE);
    end
  end

  assign tpg.pattern       = w_lfsr_q;
  assign tpg.pattern_valid = r_valid;
  assign tpg.pat_idx       = r_pat_idx;
  assign tpg.last          = r_last;
  assign tpg.misr_clr      = r_misr_clr;
  assign tpg.sig_capture   = r_sig_capture;
  assign tpg.busy          = r_busy;
  assign tpg.done          = r_done;

endmodule

// File: doc/bist_tpg_ctrl.md
Name: bist_tpg_ctrl

Overview:
- Stimulus-side BIST block for the 6:3 counter test path.
- Generates the pseudo-random input patterns that drive the CUT, and sequences the session: clearing the response compactor, counting patterns, and flagging when the final signature is ready.
- The compactor clocks every cycle and has no enable, so this block owns all timing of clear and capture.

Parameters:
- WIDTH, 6, pattern and LFSR width (CUT input count).
- SEED, 6'h01, LFSR value loaded at session start. Must be non-zero unless TPG_ALLZERO_EN is defined.
- TAPS, 6'b110000, feedback mask. fb = XOR-reduce(q & TAPS). Default implements x^6+x^5+1 (maximal, period 63).
- N_PATTERNS, 63, patterns applied per session (64 when TPG_ALLZERO_EN is defined).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  session request, sampled in IDLE and DONE only.
- pattern  out  WIDTH  current LFSR state, drives CUT inputs.
- pattern_valid  out  1  high in RUN only.
- pat_idx  out  7  index of current pattern, 0..N_PATTERNS-1.
- last  out  1  high during the final RUN cycle.
- misr_clr  out  1  one-cycle pulse in LOAD; OR'd into the compactor reset.
- sig_capture  out  1  one-cycle pulse in the first DONE cycle; compactor output is final here.
- busy  out  1  high in LOAD and RUN.
- done  out  1  high in DONE.

Behaviour:
- Reset: state=IDLE, lfsr=SEED, pat_idx=0. All 1-bit outputs are 0 and pattern=SEED. Reset applied in any state aborts the session the same way; no capture pulse is issued.
- FSM states: IDLE, LOAD, RUN, DONE.
  - IDLE: start=1 -> LOAD.
  - LOAD: exactly 1 cycle. lfsr<=SEED, pat_idx<=0, misr_clr=1. Next state is RUN.
  - RUN: each cycle, lfsr<=next(lfsr) and pat_idx<=pat_idx+1. When pat_idx==N_PATTERNS-1 (last=1), next state is DONE and lfsr/pat_idx hold.
  - DONE: sig_capture=1 on the first cycle only; done stays high. start=1 -> LOAD (restart). Otherwise remain in DONE.
- start while in LOAD or RUN is ignored.
- Latency: start sampled at edge t -> misr_clr high in cycle t+1 -> pattern=SEED with pattern_valid in cycle t+2.
  - Pattern k is presented in cycle t+2+k.
  - sig_capture occurs in cycle t+2+N_PATTERNS.
- next(q) = {q[WIDTH-2:0], fb} (shift left, feedback into bit 0).
- Default sequence from SEED=01: 01,02,04,08,10,21,03,06,0C,18,31,22,05,... The period is 63 and state 20 wraps to 01.
- pat_idx is 7 bits so that N_PATTERNS=64 fits. It never wraps within a session.
- No X or unknown states: an illegal encoding decodes to IDLE.

Optional Feature:
- Macro: TPG_ALLZERO_EN.
- Defined:
  - fb' = fb ^ (q[WIDTH-2:0]==0) (de Bruijn insertion), giving period 64.
  - 20 -> 00 -> 01. The all-zero vector is applied to the CUT.
  - N_PATTERNS default becomes 64.
  - SEED=0 is legal.
- Undefined:
  - Plain maximal LFSR, period 63, N_PATTERNS default 63.
  - The 00 pattern never appears.

Decomposition:
- Package bist_pkg holds:
  - the state enum (IDLE/LOAD/RUN/DONE);
  - the default SEED and TAPS;
  - the N_PATTERNS default, selected by TPG_ALLZERO_EN.
- Sub-module lfsr_core (WIDTH, TAPS): ports clk, reset, load, seed, adv, q. It contains the feedback logic and the optional zero insertion.
- The FSM, counter and strobes live in bist_tpg_ctrl.

Test Plan:
- Reset -> IDLE: pattern=01, all strobes 0. After start: misr_clr pulses once, then patterns 01,02,04,08,10,21,03,06,0C,18,31,22,05 on consecutive cycles with pattern_valid=1.
- Full session (default): exactly 63 valid cycles. All 63 non-zero values appear once, with no 00. last is high with pat_idx=62. sig_capture pulses 1 cycle later. done stays high until start.
- start asserted continuously during RUN: the session still lasts 63 cycles. A second start in DONE -> LOAD, and the sequence replays from 01 with pat_idx=0.
- reset asserted at pat_idx=30: the next cycle is IDLE with pattern=01, pat_idx=0, busy=0, and no sig_capture.
- With TPG_ALLZERO_EN: 64 valid cycles. The sequence contains 20,00,01 in that order and all 64 values occur once. sig_capture occurs in cycle t+66 after start is sampled at t.
- Pair with the compactor and a golden model: compare the signature latched on sig_capture against the reference. Injecting a stuck-at on one CUT output must produce a mismatch.
